parport_receiver: RTL and testbench
===================================

// Module: parport_receiver
// PURPOSE
//  Device (printer) end of the Centronics-style parallel port driven by the ST core:
//  - samples pp_strobe_n/pp_data, answers with pp_busy/pp_ack_n;
//  - queues received bytes in a FWFT FIFO for a consumer (MCU bridge, loopback bench).
//  Sits in the clk32 domain; pads arrive asynchronously from the host side.
// PARAMETERS
//  FIFO_AW      4    FIFO address width; depth = 2**FIFO_AW bytes
//  STROBE_FILT  3    consecutive synced samples needed to accept a strobe level change (>=1)
//  ACK_CYCLES   160  pp_ack_n low pulse length in clk32 cycles (5 us @ 32 MHz; >=1)
// PORTS
//  clk32        in   1          system clock (32 MHz)
//  reset        in   1          synchronous, active-high reset
//  enable       in   1          0 = offline: no capture, pp_busy forced 1
//  pp_strobe_n  in   1          host strobe, active low, asynchronous
//  pp_data      in   8          host data, asynchronous, stable while strobe low
//  pp_busy      out  1          device busy to host, active high
//  pp_ack_n     out  1          acknowledge pulse to host, active low
//  rx_data      out  8          FIFO head byte (valid when rx_valid)
//  rx_valid     out  1          FIFO not empty
//  rx_ready     in   1          consumer pops head when rx_valid & rx_ready
//  rx_count     out  FIFO_AW+1  bytes currently queued
//  rx_overflow  out  1          sticky: a byte was dropped because FIFO was full
//  rx_ovf_clr   in   1          clears rx_overflow (set wins if same cycle)
// BEHAVIOUR
//  Reset: pp_busy=0, pp_ack_n=1, rx_valid=0, rx_count=0, rx_overflow=0, state IDLE,
//   filtered strobe=1, sync flops=1. Reset mid-handshake aborts it; FIFO contents lost.
//  Input path: pp_strobe_n and pp_data each through 2-flop synchronizer.
//   Filter: strobe_f changes only after STROBE_FILT consecutive synced samples of new level.
//   Strobe event = strobe_f 1->0 transition (single cycle). Bus low at reset => no event
//   until it has been seen high (filtered) then low again.
//  Capture: on event cycle, synced pp_data is pushed (data held by host during strobe).
//   Push accepted if rx_count<DEPTH or a pop occurs same cycle; otherwise byte dropped,
//   rx_overflow set. Handshake proceeds identically in both cases.
//  FSM (registered outputs, update cycle after transition):
//   IDLE:  pp_busy = ~enable | fifo_full; pp_ack_n=1. event & enable -> ACK.
//          Event while enable=0 is ignored (stays IDLE).
//   ACK:   pp_busy=1, pp_ack_n=0 for exactly ACK_CYCLES cycles (counter) -> WAIT_HI.
//   WAIT_HI: pp_busy=1, pp_ack_n=1; strobe_f==1 -> IDLE.
//  Latency: pad strobe fall -> pp_busy high = 2 (sync) + STROBE_FILT + 1 cycles.
//  FIFO: first-word-fall-through; rx_data valid same cycle rx_valid rises; push->rx_valid
//   next cycle. Simultaneous push/pop: count unchanged. Pointers wrap modulo DEPTH;
//   rx_count = 0..DEPTH inclusive. Pop when empty has no effect.
//  enable dropped mid-handshake: current handshake completes; IDLE then holds pp_busy=1.
// TESTING
//  1 Strobe 0x5A low 1 us: pp_busy rises at +6 cycles (FILT=3), pp_ack_n low 160 cycles,
//    rx_valid=1 rx_data=0x5A rx_count=1; pp_busy=0 after strobe high + filter.
//  2 Stream 0x00..0x0F, rx_ready=0: rx_count=16, pp_busy stays 1 in IDLE; 17th strobe
//    acked but dropped, rx_overflow=1; pop all -> 0x00..0x0F in order, rx_ovf_clr clears.
//  3 Glitch: strobe low 2 cycles only -> no push, pp_busy/pp_ack_n unchanged.
//  4 FIFO full, strobe event coincident with pop -> byte accepted, rx_count stays 16,
//    rx_overflow stays 0.
//  5 reset during ACK: next cycle pp_ack_n=1, pp_busy=0, rx_count=0; strobe still low
//    -> no capture until strobe returns high and falls again.
//  6 enable=0: pp_busy=1, strobes ignored (rx_count 0); enable=1 -> normal capture.

Source files
------------

// File: rtl/parport_receiver.sv
// Device end of a Centronics-style parallel port: synchronises and filters the host strobe,
// runs the busy/ack handshake and queues received bytes in a first-word-fall-through FIFO.
`timescale 1ns/1ps
module parport_receiver #(
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned STROBE_FILT = 3,
  parameter int unsigned ACK_CYCLES  = 160
) (
  input  logic             clk32,
  input  logic             reset,
  input  logic             enable,
  input  logic             pp_strobe_n,
  input  logic [7:0]       pp_data,
  output logic             pp_busy,
  output logic             pp_ack_n,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [FIFO_AW:0] rx_count,
  output logic             rx_overflow,
  input  logic             rx_ovf_clr
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam int unsigned FiltW = $clog2(STROBE_FILT + 1);
  localparam int unsigned AckW  = $clog2(ACK_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAck, StWaitHi} state_e;

  logic             strobe_s1_q, strobe_s2_q;
  logic [7:0]       data_s1_q, data_s2_q;
  logic             strobe_f_q, strobe_fd_q, armed_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_hit, filt_done, strobe_ev;

  // A high level must be confirmed by the filter before a fall counts, so a bus that is
  // already low when reset releases cannot produce a spurious capture.
  assign filt_hit  = (strobe_s2_q != strobe_f_q) | (strobe_s2_q & ~armed_q);
  assign filt_done = filt_hit & (filt_cnt_q == FiltW'(STROBE_FILT - 1));
  assign strobe_ev = strobe_fd_q & ~strobe_f_q & armed_q;

  always_ff @(posedge clk32) begin
    if (reset) begin
      strobe_s1_q <= 1'b1;
      strobe_s2_q <= 1'b1;
      data_s1_q   <= 8'h00;
      data_s2_q   <= 8'h00;
      strobe_f_q  <= 1'b1;
      strobe_fd_q <= 1'b1;
      armed_q     <= 1'b0;
      filt_cnt_q  <= '0;
    end else begin
      strobe_s1_q <= pp_strobe_n;
      strobe_s2_q <= strobe_s1_q;
      data_s1_q   <= pp_data;
      data_s2_q   <= data_s1_q;
      strobe_fd_q <= strobe_f_q;
      if (!filt_hit) begin
        filt_cnt_q <= '0;
      end else if (filt_done) begin
        filt_cnt_q <= '0;
        strobe_f_q <= strobe_s2_q;
        armed_q    <= armed_q | strobe_s2_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  // FIFO
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    rx_count_q, rx_count_d;
  logic               ovf_q;
  logic               fifo_full, pop, push_req, push, drop;

  assign fifo_full = (rx_count_q == CntW'(Depth));
  assign pop       = rx_ready & (rx_count_q != '0);
  assign push_req  = strobe_ev & enable;
  assign push      = push_req & (~fifo_full | pop);
  assign drop      = push_req & ~push;

  always_comb begin
    rx_count_d = rx_count_q;
    if (push & ~pop) begin
      rx_count_d = rx_count_q + CntW'(1);
    end else if (pop & ~push) begin
      rx_count_d = rx_count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk32) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_s2_q;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_count_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      rx_count_q <= rx_count_d;
      ovf_q      <= (ovf_q & ~rx_ovf_clr) | drop;
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (rx_count_q != '0);
  assign rx_count    = rx_count_q;
  assign rx_overflow = ovf_q;

  // Handshake FSM; outputs are registered alongside the state they belong to.
  state_e          state_q;
  logic [AckW-1:0] ack_cnt_q;
  logic            busy_q, ack_n_q;
  logic            idle_busy;

  assign idle_busy = ~enable | (rx_count_d == CntW'(Depth));

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q   <= StIdle;
      ack_cnt_q <= '0;
      busy_q    <= 1'b0;
      ack_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (strobe_ev && enable) begin
            state_q   <= StAck;
            ack_cnt_q <= '0;
            busy_q    <= 1'b1;
            ack_n_q   <= 1'b0;
          end else begin
            busy_q <= idle_busy;
          end
        end
        StAck: begin
          if (ack_cnt_q == AckW'(ACK_CYCLES - 1)) begin
            state_q <= StWaitHi;
            ack_n_q <= 1'b1;
          end else begin
            ack_cnt_q <= ack_cnt_q + AckW'(1);
          end
        end
        StWaitHi: begin
          if (strobe_f_q) begin
            state_q <= StIdle;
            busy_q  <= idle_busy;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pp_busy  = busy_q;
  assign pp_ack_n = ack_n_q;

endmodule

// File: tb/tb_parport_receiver.sv
// Self-checking bench for parport_receiver: directed handshake/FIFO corner cases, a vector
// table, and a randomized host/consumer run checked against a byte-queue model.
`timescale 1ns/1ps
module tb_parport_receiver;

  localparam int FiltN = 3;
  localparam int AckN  = 160;
  localparam int Depth = 16;

  logic       clk32 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       pp_strobe_n = 1'b1;
  logic [7:0] pp_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ovf_clr = 1'b0;
  logic       pp_busy, pp_ack_n, rx_valid, rx_overflow;
  logic [7:0] rx_data;
  logic [4:0] rx_count;

  parport_receiver #(
    .FIFO_AW    (4),
    .STROBE_FILT(FiltN),
    .ACK_CYCLES (AckN)
  ) dut (
    .clk32      (clk32),
    .reset      (reset),
    .enable     (enable),
    .pp_strobe_n(pp_strobe_n),
    .pp_data    (pp_data),
    .pp_busy    (pp_busy),
    .pp_ack_n   (pp_ack_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_count   (rx_count),
    .rx_overflow(rx_overflow),
    .rx_ovf_clr (rx_ovf_clr)
  );

  always #5 clk32 = ~clk32;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: bytes the consumer should see, and the sticky overflow flag.
  logic [7:0] mq[$];
  bit         movf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk32);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    movf = 1'b0;
    repeat (10) tick();
  endtask

  // Host strobe of `low` cycles; returns whether the device acknowledged it.
  task automatic pulse(input logic [7:0] d, input int low, output bit acked);
    int n;
    acked = 1'b0;
    pp_data = d;
    pp_strobe_n = 1'b0;
    for (int i = 0; i < low; i++) begin
      tick();
      if (!pp_ack_n) acked = 1'b1;
    end
    pp_strobe_n = 1'b1;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      if (!pp_ack_n) acked = 1'b1;
    end
    if (acked) begin
      n = 0;
      while (!pp_ack_n && n < 400) begin
        tick();
        n++;
      end
      if (n >= 400) check("ack_release_timeout", 0, 1);
      repeat (8) tick();
    end
  endtask

  task automatic host_send(input logic [7:0] d, input int low);
    bit acked;
    bit exp_ack;
    exp_ack = (low >= FiltN) && enable;
    pulse(d, low, acked);
    check("acked", int'(acked), int'(exp_ack));
    if (exp_ack) begin
      if (mq.size() < Depth) mq.push_back(d);
      else movf = 1'b1;
    end
  endtask

  task automatic pop_check(input string name);
    if (mq.size() == 0) return;
    check({name, "_valid"}, int'(rx_valid), 1);
    check({name, "_data"}, int'(rx_data), int'(mq[0]));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(mq.pop_front());
  endtask

  task automatic check_idle(input string name);
    check({name, "_count"}, int'(rx_count), mq.size());
    check({name, "_valid"}, int'(rx_valid), int'(mq.size() != 0));
    check({name, "_ovf"}, int'(rx_overflow), int'(movf));
    check({name, "_busy"}, int'(pp_busy), int'(!enable || mq.size() == Depth));
  endtask

  typedef struct {
    logic [7:0] data;
    int         low;
    bit         exp_ack;
    int         exp_cnt;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int k;
    int lowcnt;
    bit acked;

    vecs[0] = '{8'h11, 3,  1'b1, 1, 8'h11};
    vecs[1] = '{8'h22, 2,  1'b0, 1, 8'h11};
    vecs[2] = '{8'h33, 1,  1'b0, 1, 8'h11};
    vecs[3] = '{8'h44, 40, 1'b1, 2, 8'h11};
    vecs[4] = '{8'h55, 4,  1'b1, 3, 8'h11};
    vecs[5] = '{8'h66, 2,  1'b0, 3, 8'h11};

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_busy", int'(pp_busy), 0);
    check("rst_ack_n", int'(pp_ack_n), 1);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_count", int'(rx_count), 0);
    check("rst_ovf", int'(rx_overflow), 0);
    do_reset();

    // Single byte: latency, ack width, FIFO head
    pp_data = 8'h5A;
    pp_strobe_n = 1'b0;
    k = 0;
    while (!pp_busy && k < 20) begin
      tick();
      k++;
    end
    check("t1_busy_latency", k, 2 + FiltN + 1);
    check("t1_ack_low_at_busy", int'(pp_ack_n), 0);
    lowcnt = 0;
    while (!pp_ack_n && lowcnt < 400) begin
      lowcnt++;
      tick();
      k++;
      if (k == 32) pp_strobe_n = 1'b1;
    end
    check("t1_ack_width", lowcnt, AckN);
    check("t1_busy_at_ack_end", int'(pp_busy), 1);
    check("t1_valid", int'(rx_valid), 1);
    check("t1_data", int'(rx_data), 8'h5A);
    check("t1_count", int'(rx_count), 1);
    tick();
    check("t1_busy_released", int'(pp_busy), 0);
    mq.push_back(8'h5A);
    pop_check("t1_pop");
    check_idle("t1_end");

    // Vector table, starting from an empty FIFO
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].data, vecs[i].low, acked);
      check($sformatf("vec%0d_ack", i), int'(acked), int'(vecs[i].exp_ack));
      check($sformatf("vec%0d_count", i), int'(rx_count), vecs[i].exp_cnt);
      check($sformatf("vec%0d_head", i), int'(rx_data), int'(vecs[i].exp_head));
      check($sformatf("vec%0d_ack_n", i), int'(pp_ack_n), 1);
    end
    mq.push_back(8'h11);
    mq.push_back(8'h44);
    mq.push_back(8'h55);
    while (mq.size() != 0) pop_check("vec_pop");

    // Fill to depth, then overflow
    do_reset();
    for (int i = 0; i < Depth; i++) host_send(8'(i), 20);
    check_idle("t2_full");
    host_send(8'hAA, 20);
    check("t2_count_after_drop", int'(rx_count), Depth);
    check("t2_ovf", int'(rx_overflow), 1);
    while (mq.size() != 0) pop_check("t2_pop");
    tick();
    check_idle("t2_drained");
    rx_ovf_clr = 1'b1;
    tick();
    rx_ovf_clr = 1'b0;
    movf = 1'b0;
    check("t2_ovf_cleared", int'(rx_overflow), 0);

    // Strobe glitch on an idle port
    do_reset();
    host_send(8'hE1, 2);
    check("t3_ack_n", int'(pp_ack_n), 1);
    check_idle("t3");

    // Full FIFO, push coincident with pop
    do_reset();
    for (int i = 0; i < Depth; i++) host_send(8'h80 + 8'(i), 12);
    pp_data = 8'hC3;
    pp_strobe_n = 1'b0;
    repeat (2 + FiltN) tick();
    check("t4_head_before", int'(rx_data), int'(mq[0]));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(mq.pop_front());
    mq.push_back(8'hC3);
    check("t4_count", int'(rx_count), Depth);
    check("t4_ovf", int'(rx_overflow), 0);
    repeat (26) tick();
    pp_strobe_n = 1'b1;
    k = 0;
    while (!pp_ack_n && k < 400) begin
      tick();
      k++;
    end
    repeat (8) tick();
    check_idle("t4_after");
    while (mq.size() != 0) pop_check("t4_pop");

    // Reset in the middle of an acknowledge
    do_reset();
    pp_data = 8'h77;
    pp_strobe_n = 1'b0;
    repeat (20) tick();
    check("t5_ack_active", int'(pp_ack_n), 0);
    check("t5_count_before", int'(rx_count), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_ack_n", int'(pp_ack_n), 1);
    check("t5_busy", int'(pp_busy), 0);
    check("t5_count", int'(rx_count), 0);
    repeat (30) tick();
    check("t5_low_count", int'(rx_count), 0);
    check("t5_low_ack_n", int'(pp_ack_n), 1);
    check("t5_low_busy", int'(pp_busy), 0);
    pp_strobe_n = 1'b1;
    mq.delete();
    movf = 1'b0;
    repeat (10) tick();
    host_send(8'h88, 20);
    check_idle("t5_recover");
    pop_check("t5_pop");

    // Offline device
    do_reset();
    enable = 1'b0;
    repeat (2) tick();
    check("t6_busy_offline", int'(pp_busy), 1);
    host_send(8'h99, 20);
    check_idle("t6_offline");
    enable = 1'b1;
    repeat (2) tick();
    check("t6_busy_online", int'(pp_busy), 0);
    host_send(8'h9A, 20);
    check_idle("t6_online");
    pop_check("t6_pop");

    // Randomized host and consumer
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        host_send(8'($urandom_range(0, 255)), $urandom_range(FiltN, 40));
      end else if (op == 3) begin
        host_send(8'($urandom_range(0, 255)), $urandom_range(1, FiltN - 1));
      end else if (op == 4) begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n && mq.size() != 0; j++) pop_check("rnd_pop");
        tick();
      end else begin
        rx_ovf_clr = 1'b1;
        tick();
        rx_ovf_clr = 1'b0;
        movf = 1'b0;
      end
      check_idle($sformatf("rnd%0d", it));
    end
    while (mq.size() != 0) pop_check("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
